// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, 8 data bits MSB first, STOP_BITS stop bits; line idles high.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int              BW        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tick;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  assign tick = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    baud_d  = (state_q == IDLE || tick) ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          shift_d = tx_data;
          bit_d   = 3'd0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {shift_q[6:0], 1'b0};
          // bit 7 is the terminal count; the counter is cleared rather than wrapped
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = 3'd0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the next state so tx leaves a flop, glitch-free.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[7];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= 8'd0;
      bit_q    <= 3'd0;
      baud_q   <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (1 clk/bit, 4 clk/bit, 3 clk/bit with 2 stop bits).
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] st;
  logic [7:0] d [3];
  logic [2:0] tx_w, busy_w, done_w;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_start(st[0]), .tx_data(d[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_start(st[1]), .tx_data(d[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .tx_start(st[2]), .tx_data(d[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("%s u%0d tx", tag, s), 32'(tx_w[s]), 32'd1);
      chk($sformatf("%s u%0d busy", tag, s), 32'(busy_w[s]), 32'd0);
      chk($sformatf("%s u%0d done", tag, s), 32'(done_w[s]), 32'd0);
    end
  endtask

  // Expects tx_start already high; the next rising edge accepts. After the first
  // frame cycle tx_data is replaced by nd and tx_start optionally dropped.
  task automatic check_frame(input int sel, input logic [7:0] b, input int cpb, input int sb,
                             input string tag, input logic [7:0] nd, input bit drop);
    int   nb;
    int   k;
    logic e;
`ifdef UART_TX_PARITY_EN
    nb = 10 + sb;
`else
    nb = 9 + sb;
`endif
    @(posedge clk);
    for (int i = 0; i < nb * cpb; i++) begin
      @(negedge clk);
      k = i / cpb;
      if (k == 0)      e = 1'b0;
      else if (k <= 8) e = b[8 - k];
`ifdef UART_TX_PARITY_EN
      else if (k == 9) e = ^b;
`endif
      else             e = 1'b1;
      chk($sformatf("%s tx c%0d", tag, i), 32'(tx_w[sel]), 32'(e));
      chk($sformatf("%s busy c%0d", tag, i), 32'(busy_w[sel]), 32'd1);
      chk($sformatf("%s done c%0d", tag, i), 32'(done_w[sel]), 32'd0);
      if (i == 0) begin
        d[sel] = nd;
        if (drop) st[sel] = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done_w[sel]), 32'd1);
    chk({tag, " busy end"}, 32'(busy_w[sel]), 32'd0);
    chk({tag, " tx end"}, 32'(tx_w[sel]), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    st  = '0;
    for (int s = 0; s < 3; s++) d[s] = 8'h00;

    // Asynchronous reset mid-cycle, before any clock edge
    #2 rst = 1'b1;
    #1 chk_idle("rst async");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk_idle("rst idle");
    end

    // 0xA5 at one clock per bit
    st[0] = 1'b1; d[0] = 8'hA5;
    check_frame(0, 8'hA5, 1, 1, "a5", 8'hA5, 1'b1);

    // 0x01 at four clocks per bit
    @(negedge clk);
    st[1] = 1'b1; d[1] = 8'h01;
    check_frame(1, 8'h01, 4, 1, "c4", 8'h01, 1'b1);

    // two stop bits, three clocks per bit
    @(negedge clk);
    st[2] = 1'b1; d[2] = 8'h96;
    check_frame(2, 8'h96, 3, 2, "sb2", 8'h96, 1'b1);

    // back-to-back with tx_start held and tx_data swapped while busy
    @(negedge clk);
    st[0] = 1'b1; d[0] = 8'h3C;
    check_frame(0, 8'h3C, 1, 1, "b2b1", 8'hC3, 1'b0);
    check_frame(0, 8'hC3, 1, 1, "b2b2", 8'h55, 1'b1);
    @(negedge clk);
    chk("b2b idle busy", 32'(busy_w[0]), 32'd0);
    chk("b2b idle done", 32'(done_w[0]), 32'd0);

    // reset during the third data bit of 0xFF
    @(negedge clk);
    st[0] = 1'b1; d[0] = 8'hFF;
    @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort pre busy", 32'(busy_w[0]), 32'd1);
    chk("abort pre tx", 32'(tx_w[0]), 32'd1);
    #1 rst = 1'b1;
    #1 chk_idle("abort rst");
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk_idle("abort after");
    end
    st[0] = 1'b1; d[0] = 8'hFF;
    check_frame(0, 8'hFF, 1, 1, "fresh", 8'h00, 1'b1);

`ifdef UART_TX_PARITY_EN
    @(negedge clk);
    st[0] = 1'b1; d[0] = 8'h07;
    check_frame(0, 8'h07, 1, 1, "par07", 8'h07, 1'b1);
    @(negedge clk);
    st[0] = 1'b1; d[0] = 8'h03;
    check_frame(0, 8'h03, 1, 1, "par03", 8'h03, 1'b1);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
